// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic cells.
package serial_arith_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor built from two half-subtractor cells.
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);
   assign d    = a ^ b;
   assign bout = ~a & b;
endmodule

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic d1, b1, b2;

   half_subtractor u_hs0 (.a(a),  .b(b),   .d(d1), .bout(b1));
   // The second stage borrows only when a^b is 0 and a borrow comes in.
   half_subtractor u_hs1 (.a(d1), .b(bin), .d(d),  .bout(b2));

   assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock between two valid/ready streams.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh, b_sh, res;
   logic             bflop;
   logic [CW-1:0]    cnt;
   logic             d, bout;

   full_subtractor u_fs (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .bin (bflop),
      .d   (d),
      .bout(bout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         diff      <= '0;
         borrow    <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         res       <= '0;
         bflop     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  bflop    <= 1'b0;
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               res   <= {d, res[WIDTH-1:1]};
               bflop <= bout;
               cnt   <= cnt + 1'b1;
               // Outputs load from the final bit directly so they stay put until the next op finishes.
               if (cnt == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  diff      <= {d, res[WIDTH-1:1]};
                  borrow    <= bout;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule
